// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM stage controller and the data memory.
// The master drives the request; the slave answers with ack and read data.
interface mem_stage_ctrl_if;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [3:0]  dm_web;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req,
        output dm_addr,
        output dm_web,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_addr,
        input  dm_web,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: sequences one data-memory access per instruction,
// stalls upstream while it is in flight and feeds the MEM/WB register.
module mem_stage_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        MemRead_in,
    input  logic [3:0]  MemWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] MemWD_in,
    input  logic [4:0]  RegRd_in,
    input  logic        RegWrite_in,
    input  logic        selMuxWB_in,
    mem_stage_ctrl_if.master dm,
    output logic        stall_out,
    output logic [4:0]  RegRd_out,
    output logic        RegWrite_out,
    output logic        selMuxWB_out,
    output logic [31:0] alu_out,
    output logic [31:0] ld_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic        access;
    logic        stall;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  web_q, web_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        sel_q, sel_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] ld_q, ld_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        access  = MemRead_in | (MemWrite_in != 4'b1111);
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        web_d   = web_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    addr_d  = addr_in;
                    web_d   = MemRead_in ? 4'b1111 : MemWrite_in;
                    wdata_d = MemWD_in;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dm.dm_ack) begin
                    rdata_d = dm.dm_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane select uses the latched address, not the live one.
    always_comb begin
        ld_byte = rdata_q[7:0];
        case (addr_q[1:0])
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            2'd3:    ld_byte = rdata_q[31:24];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (funct3_in)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = rdata_q;
        endcase
    end

    always_comb begin
        rd_d  = rd_q;
        rw_d  = 1'b0;
        sel_d = sel_q;
        alu_d = alu_q;
        ld_d  = ld_q;
        if (!stall) begin
            rd_d  = RegRd_in;
            rw_d  = RegWrite_in;
            sel_d = selMuxWB_in;
            alu_d = addr_in;
            ld_d  = MemRead_in ? ld_ext : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= 32'd0;
            web_q   <= 4'b1111;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            rd_q    <= 5'd0;
            rw_q    <= 1'b0;
            sel_q   <= 1'b0;
            alu_q   <= 32'd0;
            ld_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            web_q   <= web_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            sel_q   <= sel_d;
            alu_q   <= alu_d;
            ld_q    <= ld_d;
        end
    end

    assign dm.dm_req    = req_q;
    assign dm.dm_addr   = addr_q;
    assign dm.dm_web    = web_q;
    assign dm.dm_wdata  = wdata_q;
    assign stall_out    = stall;
    assign RegRd_out    = rd_q;
    assign RegWrite_out = rw_q;
    assign selMuxWB_out = sel_q;
    assign alu_out      = alu_q;
    assign ld_data_out  = ld_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed table, reset/stray-ack sequences and
// randomized instructions checked against a transaction-level model.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        MemRead_in;
    logic [3:0]  MemWrite_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] MemWD_in;
    logic [4:0]  RegRd_in;
    logic        RegWrite_in;
    logic        selMuxWB_in;
    logic        stall_out;
    logic [4:0]  RegRd_out;
    logic        RegWrite_out;
    logic        selMuxWB_out;
    logic [31:0] alu_out;
    logic [31:0] ld_data_out;

    mem_stage_ctrl_if bus();

    mem_stage_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .MemRead_in   (MemRead_in),
        .MemWrite_in  (MemWrite_in),
        .funct3_in    (funct3_in),
        .addr_in      (addr_in),
        .MemWD_in     (MemWD_in),
        .RegRd_in     (RegRd_in),
        .RegWrite_in  (RegWrite_in),
        .selMuxWB_in  (selMuxWB_in),
        .dm           (bus),
        .stall_out    (stall_out),
        .RegRd_out    (RegRd_out),
        .RegWrite_out (RegWrite_out),
        .selMuxWB_out (selMuxWB_out),
        .alu_out      (alu_out),
        .ld_data_out  (ld_data_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rd_en;
        logic [3:0]  we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        sel;
        int          waitc;
        logic [31:0] rdata;
        logic [31:0] exp_ld;
        int          exp_stall;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Loaded value from the rules: shift the addressed lane down, then extend.
    function automatic logic [31:0] ref_ld(input logic rd_en, input logic [2:0] f3,
                                           input logic [31:0] a, input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        if (!rd_en) return 32'd0;
        b = (d >> (8 * a[1:0])) & 32'hFF;
        h = (d >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        MemRead_in  = v.rd_en;
        MemWrite_in = v.we;
        funct3_in   = v.f3;
        addr_in     = v.addr;
        MemWD_in    = v.wd;
        RegRd_in    = v.rd;
        RegWrite_in = v.rw;
        selMuxWB_in = v.sel;
    endtask

    // Called at a falling edge; returns at the falling edge after MEM/WB loads.
    task automatic run(input vec_t v, input string tag);
        int   stalls = 0;
        int   reqs = 0;
        int   first_req = -1;
        int   cyc = 0;
        logic s;
        logic acc;
        logic [3:0] wexp;
        drive(v);
        bus.dm_ack = 1'b0;
        acc  = v.rd_en || (v.we != 4'b1111);
        wexp = v.rd_en ? 4'b1111 : v.we;
        forever begin
            #1;
            s = stall_out;
            if (s) stalls++;
            if (cyc > 0 && s) chk({tag, " bubble"}, {31'd0, RegWrite_out}, 32'd0);
            if (bus.dm_req) begin
                if (first_req < 0) first_req = cyc;
                chk({tag, " dm_addr"}, bus.dm_addr, v.addr);
                chk({tag, " dm_web"}, {28'd0, bus.dm_web}, {28'd0, wexp});
                chk({tag, " dm_wdata"}, bus.dm_wdata, v.wd);
                bus.dm_ack   = (reqs == v.waitc);
                bus.dm_rdata = bus.dm_ack ? v.rdata : $urandom;
                reqs++;
            end else begin
                bus.dm_ack = 1'b0;
            end
            @(negedge clk);
            bus.dm_ack = 1'b0;
            cyc++;
            if (!s) break;
            if (cyc > 40) begin
                chk({tag, " timeout"}, 32'd1, 32'd0);
                break;
            end
        end
        chk({tag, " stall_cycles"}, stalls, v.exp_stall);
        chk({tag, " req_cycles"}, reqs, acc ? v.waitc + 1 : 0);
        chk({tag, " req_start"}, first_req, acc ? 1 : -1);
        chk({tag, " RegWrite_out"}, {31'd0, RegWrite_out}, {31'd0, v.rw});
        chk({tag, " RegRd_out"}, {27'd0, RegRd_out}, {27'd0, v.rd});
        chk({tag, " selMuxWB_out"}, {31'd0, selMuxWB_out}, {31'd0, v.sel});
        chk({tag, " alu_out"}, alu_out, v.addr);
        chk({tag, " ld_data_out"}, ld_data_out, v.exp_ld);
        chk({tag, " dm_req_after"}, {31'd0, bus.dm_req}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " dm_req"}, {31'd0, bus.dm_req}, 32'd0);
        chk({tag, " dm_addr"}, bus.dm_addr, 32'd0);
        chk({tag, " dm_web"}, {28'd0, bus.dm_web}, 32'hF);
        chk({tag, " dm_wdata"}, bus.dm_wdata, 32'd0);
        chk({tag, " RegWrite_out"}, {31'd0, RegWrite_out}, 32'd0);
        chk({tag, " RegRd_out"}, {27'd0, RegRd_out}, 32'd0);
        chk({tag, " alu_out"}, alu_out, 32'd0);
        chk({tag, " ld_data_out"}, ld_data_out, 32'd0);
    endtask

    vec_t nop_v;
    vec_t rv;

    initial begin
        tbl[0] = '{1'b0, 4'hF, 3'd0, 32'h0000_0010, 32'h0, 5'd3, 1'b1, 1'b0, 0, 32'h0, 32'h0, 0};
        tbl[1] = '{1'b1, 4'hF, 3'd0, 32'h0000_1003, 32'h0, 5'd5, 1'b1, 1'b1, 0, 32'h80FF_1234, 32'hFFFF_FF80, 2};
        tbl[2] = '{1'b0, 4'b0011, 3'd1, 32'h0000_3002, 32'hABCD_0000, 5'd0, 1'b0, 1'b0, 3, 32'h0, 32'h0, 5};
        tbl[3] = '{1'b1, 4'hF, 3'd5, 32'h0000_2002, 32'h0, 5'd6, 1'b1, 1'b1, 0, 32'h9876_0000, 32'h0000_9876, 2};
        tbl[4] = '{1'b1, 4'hF, 3'd2, 32'h0000_2004, 32'h0, 5'd7, 1'b1, 1'b1, 1, 32'h1234_5678, 32'h1234_5678, 3};
        tbl[5] = '{1'b1, 4'hF, 3'd1, 32'h0000_0100, 32'h0, 5'd8, 1'b1, 1'b1, 2, 32'h0000_8001, 32'hFFFF_8001, 4};
        tbl[6] = '{1'b1, 4'hF, 3'd4, 32'h0000_0101, 32'h0, 5'd9, 1'b1, 1'b0, 0, 32'h0000_C300, 32'h0000_00C3, 2};
        tbl[7] = '{1'b0, 4'b0000, 3'd2, 32'h0000_0200, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 0, 32'h0, 32'h0, 2};
        tbl[8] = '{1'b0, 4'hF, 3'd0, 32'hFFFF_FFFF, 32'h0, 5'd31, 1'b1, 1'b1, 0, 32'h0, 32'h0, 0};
        nop_v  = '{1'b0, 4'hF, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 0, 32'h0, 32'h0, 0};

        drive(nop_v);
        bus.dm_ack   = 1'b0;
        bus.dm_rdata = 32'h0;
        #1 resetn = 1'b0;
        #1;
        chk_reset_outputs("reset");
        chk("reset stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // Reset while BUSY abandons the access.
        drive(tbl[4]);
        @(negedge clk);
        #1;
        chk("rstbusy req_before", {31'd0, bus.dm_req}, 32'd1);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("rstbusy");
        drive(nop_v);
        @(negedge clk);
        resetn = 1'b1;

        // Stray acks while idle with no access are ignored.
        for (int k = 0; k < 3; k++) begin
            bus.dm_ack   = 1'b1;
            bus.dm_rdata = 32'hFFFF_FFFF;
            #1;
            chk("stray stall", {31'd0, stall_out}, 32'd0);
            chk("stray req", {31'd0, bus.dm_req}, 32'd0);
            @(negedge clk);
        end
        bus.dm_ack = 1'b0;
        chk("stray ld_data", ld_data_out, 32'd0);
        run(tbl[6], "after_stray_lbu");

        for (int i = 0; i < 60; i++) begin
            int kind;
            kind        = $urandom_range(0, 2);
            rv.addr     = $urandom;
            rv.wd       = $urandom;
            rv.rd       = 5'($urandom);
            rv.sel      = 1'($urandom);
            rv.f3       = 3'($urandom);
            rv.rdata    = $urandom;
            rv.waitc    = $urandom_range(0, 3);
            rv.rd_en    = (kind == 1);
            rv.we       = (kind == 2) ? 4'($urandom_range(0, 14)) : 4'hF;
            rv.rw       = (kind == 2) ? 1'b0 : 1'($urandom);
            rv.exp_ld   = ref_ld(rv.rd_en, rv.f3, rv.addr, rv.rdata);
            rv.exp_stall = (kind == 0) ? 0 : 2 + rv.waitc;
            run(rv, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port MemRead_in, input, 1, load present in MEM.
REQ-004 SHALL have port MemWrite_in, input, 4, active-low byte write enables; 4'b1111 means no store.
REQ-005 SHALL have port funct3_in, input, 3, load width/sign code.
REQ-006 SHALL have port addr_in, input, 32, ALU result / effective address.
REQ-007 SHALL have port MemWD_in, input, 32, lane-aligned store data.
REQ-008 SHALL have ports RegRd_in (5), RegWrite_in (1), selMuxWB_in (1), all inputs, writeback controls of the MEM instruction.
REQ-009 SHALL have ports dm_req output 1, dm_addr output 32, dm_web output 4, dm_wdata output 32, dm_ack input 1, dm_rdata input 32, forming the data-memory bus.
REQ-010 SHALL have port stall_out, output, 1, hold request to all upstream stages (drives their NOP).
REQ-011 SHALL have ports RegRd_out (5), RegWrite_out (1), selMuxWB_out (1), alu_out (32), ld_data_out (32), all outputs, the MEM/WB register.

Function
REQ-012 SHALL define access = MemRead_in | (MemWrite_in != 4'b1111).
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 IDLE: if access, SHALL latch addr_in, MemWrite_in (forced to 4'b1111 for loads), and MemWD_in into dm_addr/dm_web/dm_wdata, set dm_req=1, and go to BUSY; otherwise SHALL stay in IDLE.
REQ-015 BUSY: SHALL hold dm_req, dm_addr, dm_web, and dm_wdata stable until dm_ack=1; on dm_ack SHALL capture dm_rdata, drop dm_req, and go to DONE.
REQ-016 DONE: SHALL return to IDLE unconditionally and SHALL NOT re-detect access in that cycle.
REQ-017 dm_ack SHALL be ignored outside BUSY.
REQ-018 stall_out SHALL be combinational: 1 when (IDLE & access) or BUSY; 0 in DONE and in IDLE without access.
REQ-019 MEM/WB register, stall_out=0: SHALL load RegRd_in, RegWrite_in, selMuxWB_in, addr_in→alu_out, and the extended load data→ld_data_out.
REQ-020 MEM/WB register, stall_out=1: SHALL load a bubble: RegWrite_out=0; other MEM/WB fields keep their values.
REQ-021 Non-access instructions SHALL pass to MEM/WB in 1 cycle with no stall.
REQ-022 Memory-access latency SHALL be min 3 cycles (IDLE, BUSY with same-cycle ack, DONE); each extra BUSY wait cycle adds one.
REQ-023 Load extension SHALL use the captured dm_rdata and latched addr[1:0]: 000 lb sign-extends byte addr[1:0]; 001 lh sign-extends half addr[1]; 100 lbu and 101 lhu zero-extend; 010 and all other codes pass the word.
REQ-024 Stores SHALL write ld_data_out = 0; the WB path still passes RegWrite_in (0 for stores).
REQ-025 dm_addr SHALL be the full 32-bit addr_in; byte selection is by dm_web.

Reset
REQ-026 resetn=0 SHALL immediately force: state IDLE, dm_req=0, dm_addr=0, dm_web=4'b1111, dm_wdata=0, captured data=0, all MEM/WB outputs 0.
REQ-027 Reset asserted in BUSY SHALL abandon the transaction; after release the block SHALL start in IDLE with no pending request.

Verification
REQ-028 add, addr_in=0x10 -> next edge alu_out=0x10, RegWrite_out=1; stall_out stays 0.
REQ-029 lb, addr=0x1003, dm_rdata=0x80FF_1234, ack in first BUSY cycle -> stall high for 2 cycles; ld_data_out=0xFFFF_FF80 after DONE edge.
REQ-030 sh, MemWrite_in=4'b0011, MemWD_in=0xABCD_0000, ack delayed 3 cycles -> dm_req high 4 cycles, dm_web=4'b0011 stable, dm_wdata=0xABCD_0000 stable; RegWrite_out=0 throughout.
REQ-031 lhu, addr=0x2002, dm_rdata=0x9876_0000, then back-to-back lw -> ld_data_out=0x0000_9876; second access enters BUSY exactly 2 cycles after the first DONE.
REQ-032 resetn pulsed low while BUSY -> dm_req=0 immediately; a stray dm_ack after release produces no capture or state change.
REQ-033 dm_ack=1 while IDLE with no access -> no state change, stall_out=0.
